sh7604_dbus_arbiter: RTL and testbench
======================================

Name: sh7604_dbus_arbiter

Overview:
Arbitrates the SH7604 external data bus (DBUS) among three requesters: the CPU core data port, the on-chip DMAC, and an external bus master using the BREQ/BACK handshake (slave-mode partner CPU). Sits between the requesters and the BSC. Grants ownership per access or per locked sequence, generates the DMAC acknowledge that drives DACK timing, and inserts a turnaround cycle on every ownership change. Fully synchronous to CLK; all state advances only on CE_R/CE_F.

Parameters:
DMA_MAX_BEATS, 8, max consecutive unlocked DMAC beats before a pending CPU request is serviced (fair mode only); 1..15
EXT_TURN, 1, idle CE_R cycles inserted before/after the external master owns the bus; 0..3

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, synchronous, active-low
CE_R  in  1  rising-phase clock enable
CE_F  in  1  falling-phase clock enable
CPU_REQ  in  1  CPU requests a DBUS access
CPU_LOCK  in  1  CPU holds bus after current beat (TAS/read-modify-write)
DMA_REQ  in  1  DMAC requests a DBUS access
DMA_LOCK  in  1  DMAC holds bus after current beat
DMA_BURST  in  1  DMAC 16-byte burst in progress (implies lock)
BREQ_N  in  1  external master bus request, active-low
BUS_WAIT  in  1  BSC wait; beat completes on CE_F with BUS_WAIT=0
CPU_GNT  out  1  CPU owns bus
DMA_GNT  out  1  DMAC owns bus
BACK_N  out  1  bus acknowledge to external master, active-low
OWNER  out  2  0 none, 1 CPU, 2 DMAC, 3 external
DMA_ACK  out  1  one-CE_F pulse at each completed DMAC beat (feeds DMAC BSC_ACK)
BUS_IDLE  out  1  no owner and no turnaround pending

Behaviour:
- Reset (RST_N=0 at CLK edge, regardless of CE): state IDLE; CPU_GNT=0, DMA_GNT=0, BACK_N=1, OWNER=0, DMA_ACK=0, BUS_IDLE=1, fairness counter=0, turnaround counter=0. Reset mid-access drops the grant immediately; no beat completes.
- States: IDLE, CPU, DMA, TURN, EXT.
- IDLE, on CE_R: priority EXT > DMA > CPU (fair exception below). Grant registered; asserted one CE_R after request seen. Selecting EXT enters TURN with count=EXT_TURN, then EXT (BACK_N=0). EXT_TURN=0 goes directly to EXT.
- CPU/DMA: a beat ends on CE_F with BUS_WAIT=0. At beat end, if the owner's LOCK (or DMA_BURST for DMAC) is 1, ownership is retained and BREQ_N is ignored. Otherwise the next CE_R re-arbitrates: the same owner continues with no gap if it still requests and wins; any owner change passes through one CE_R with OWNER=0.
- DMA_ACK: high for the CE_F..next CE_F interval in which a DMAC beat completes; never asserted outside DMA state.
- EXT: BACK_N=0 while BREQ_N=0. On BREQ_N=1 seen at CE_R: BACK_N=1, TURN for EXT_TURN cycles, then IDLE. Internal requests wait.
- Requests are level-sensitive; a requester deasserting REQ before its grant is simply not granted. Deasserting REQ while granted with LOCK=0 releases at beat end.
- Simultaneous BREQ_N fall and internal lock sequence: lock wins; EXT granted at the first unlocked beat end.
- Grants mutually exclusive; at most one of CPU_GNT, DMA_GNT, !BACK_N high (assertion-checked).
- BUS_IDLE = (state==IDLE).

Optional Feature:
SH7604_ARB_FAIR_EN: when defined, a 4-bit counter increments at each unlocked DMAC beat end while CPU_REQ=1; on reaching DMA_MAX_BEATS the next arbitration prefers CPU over DMAC (EXT remains highest), and the counter clears on any CPU grant or when CPU_REQ=0. Without the macro: strict EXT > DMA > CPU priority; the counter is absent and the CPU can be starved by continuous DMA.

Test Plan:
- Reset with CPU_REQ=1, DMA_REQ=1 held, release RST_N -> DMA_GNT=1 one CE_R later, OWNER=2, CPU_GNT=0.
- DMAC burst: DMA_BURST=1 for 4 beats with CPU_REQ=1, BREQ_N=0 -> DMA keeps bus all 4 beats, 4 DMA_ACK pulses, then idle gap of one CE_R, then BACK_N=0 after EXT_TURN=1 cycle.
- CPU_LOCK=1 for 2 beats, DMA_REQ=1 -> CPU retains bus through both; DMA_GNT after one-cycle gap.
- Fair mode, DMA_MAX_BEATS=8, continuous unlocked DMA plus CPU_REQ=1 -> CPU granted after beat 8; non-fair build -> CPU never granted while DMA_REQ=1.
- EXT ownership, BREQ_N released -> BACK_N=1 same CE_R, IDLE after EXT_TURN cycles, pending DMA granted next.
- RST_N=0 during DMA beat with BUS_WAIT=1 -> all grants 0 next edge, no DMA_ACK pulse.

Source files
------------

// File: rtl/sh7604_dbus_arbiter.sv
// SH7604 DBUS arbiter: CPU, DMAC and external BREQ/BACK master, with a turnaround on owner change.
// Define SH7604_ARB_FAIR_EN to let a starved CPU pre-empt DMAC after DMA_MAX_BEATS beats.
module sh7604_dbus_arbiter #(
  parameter int unsigned DMA_MAX_BEATS = 8,
  parameter int unsigned EXT_TURN      = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       CE_F,
  input  logic       CPU_REQ,
  input  logic       CPU_LOCK,
  input  logic       DMA_REQ,
  input  logic       DMA_LOCK,
  input  logic       DMA_BURST,
  input  logic       BREQ_N,
  input  logic       BUS_WAIT,
  output logic       CPU_GNT,
  output logic       DMA_GNT,
  output logic       BACK_N,
  output logic [1:0] OWNER,
  output logic       DMA_ACK,
  output logic       BUS_IDLE
);

  // Low two bits of StCpu/StDma match the arbitration winner code.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCpu  = 3'd1;
  localparam logic [2:0] StDma  = 3'd2;
  localparam logic [2:0] StTurn = 3'd3;
  localparam logic [2:0] StExt  = 3'd4;

  localparam logic [1:0] TurnInit = 2'(EXT_TURN);

  logic [2:0] state_q, state_d;
  logic [1:0] turn_cnt_q, turn_cnt_d;
  logic       turn_to_ext_q, turn_to_ext_d;
  logic       rel_q, rel_d;
  logic       ack_q, ack_d;
  logic       cpu_first;
  logic [1:0] win;
  logic       beat_end;
  logic       owner_lock;

  assign beat_end   = CE_F && !BUS_WAIT && (state_q == StCpu || state_q == StDma);
  assign owner_lock = (state_q == StCpu) ? CPU_LOCK : (DMA_LOCK | DMA_BURST);

`ifdef SH7604_ARB_FAIR_EN
  logic [3:0] fair_cnt_q, fair_cnt_d;

  assign cpu_first = (fair_cnt_q >= 4'(DMA_MAX_BEATS));

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if ((CE_R || CE_F) && !CPU_REQ) begin
      fair_cnt_d = '0;
    end else if (CE_R && state_d == StCpu) begin
      fair_cnt_d = '0;
    end else if (beat_end && state_q == StDma && !owner_lock && fair_cnt_q != 4'd15) begin
      fair_cnt_d = fair_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) fair_cnt_q <= '0;
    else        fair_cnt_q <= fair_cnt_d;
  end
`else
  // Never true for the legal DMA_MAX_BEATS range: strict priority.
  assign cpu_first = (DMA_MAX_BEATS == 0);
`endif

  // Winner code: 0 none, 1 CPU, 2 DMAC, 3 external.
  always_comb begin
    win = 2'd0;
    if (!BREQ_N)                  win = 2'd3;
    else if (cpu_first && CPU_REQ) win = 2'd1;
    else if (DMA_REQ)             win = 2'd2;
    else if (CPU_REQ)             win = 2'd1;
  end

  always_comb begin
    state_d       = state_q;
    turn_cnt_d    = turn_cnt_q;
    turn_to_ext_d = turn_to_ext_q;
    rel_d         = rel_q;
    ack_d         = ack_q;
    if (CE_R) begin
      case (state_q)
        StIdle: begin
          case (win)
            2'd1: state_d = StCpu;
            2'd2: state_d = StDma;
            2'd3: begin
              if (EXT_TURN == 0) begin
                state_d = StExt;
              end else begin
                state_d       = StTurn;
                turn_cnt_d    = TurnInit;
                turn_to_ext_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        StCpu, StDma: begin
          if (rel_q) begin
            rel_d = 1'b0;
            if (win != state_q[1:0]) state_d = StIdle;
          end
        end
        StTurn: begin
          if (turn_cnt_q <= 2'd1) state_d = turn_to_ext_q ? StExt : StIdle;
          else                    turn_cnt_d = turn_cnt_q - 2'd1;
        end
        StExt: begin
          if (BREQ_N) begin
            if (EXT_TURN == 0) begin
              state_d = StIdle;
            end else begin
              state_d       = StTurn;
              turn_cnt_d    = TurnInit;
              turn_to_ext_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (CE_F) begin
      ack_d = beat_end && (state_q == StDma);
      if (beat_end && !owner_lock) rel_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      turn_cnt_q    <= '0;
      turn_to_ext_q <= 1'b0;
      rel_q         <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_cnt_q    <= turn_cnt_d;
      turn_to_ext_q <= turn_to_ext_d;
      rel_q         <= rel_d;
      ack_q         <= ack_d;
    end
  end

  assign CPU_GNT  = (state_q == StCpu);
  assign DMA_GNT  = (state_q == StDma);
  assign BACK_N   = (state_q != StExt);
  assign DMA_ACK  = ack_q && (state_q == StDma);
  assign BUS_IDLE = (state_q == StIdle);

  always_comb begin
    case (state_q)
      StCpu:   OWNER = 2'd1;
      StDma:   OWNER = 2'd2;
      StExt:   OWNER = 2'd3;
      default: OWNER = 2'd0;
    endcase
  end

  assert property (@(posedge CLK) disable iff (!RST_N) $onehot0({CPU_GNT, DMA_GNT, ~BACK_N}));

endmodule

// File: tb/tb_sh7604_dbus_arbiter.sv
// Directed bench for sh7604_dbus_arbiter (EXT_TURN=1, DMA_MAX_BEATS=8), CE_R/CE_F alternating.
module tb_sh7604_dbus_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CE_R, CE_F;
  logic       CPU_REQ, CPU_LOCK, DMA_REQ, DMA_LOCK, DMA_BURST, BREQ_N, BUS_WAIT;
  logic       CPU_GNT, DMA_GNT, BACK_N, DMA_ACK, BUS_IDLE;
  logic [1:0] OWNER;
  logic       ph = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sh7604_dbus_arbiter #(
    .DMA_MAX_BEATS(8),
    .EXT_TURN     (1)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .CE_F     (CE_F),
    .CPU_REQ  (CPU_REQ),
    .CPU_LOCK (CPU_LOCK),
    .DMA_REQ  (DMA_REQ),
    .DMA_LOCK (DMA_LOCK),
    .DMA_BURST(DMA_BURST),
    .BREQ_N   (BREQ_N),
    .BUS_WAIT (BUS_WAIT),
    .CPU_GNT  (CPU_GNT),
    .DMA_GNT  (DMA_GNT),
    .BACK_N   (BACK_N),
    .OWNER    (OWNER),
    .DMA_ACK  (DMA_ACK),
    .BUS_IDLE (BUS_IDLE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) ph <= ~ph;
  assign CE_R = ~ph;
  assign CE_F = ph;

  task automatic tick_r();
    @(posedge CLK);
    while (!CE_R) @(posedge CLK);
    #1;
  endtask

  task automatic tick_f();
    @(posedge CLK);
    while (!CE_F) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; CPU_REQ = 1'b1; CPU_LOCK = 1'b0; DMA_REQ = 1'b1; DMA_LOCK = 1'b0;
    DMA_BURST = 1'b0; BREQ_N = 1'b1; BUS_WAIT = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (CPU_GNT !== 1'b0) begin n_err++; $error("FAIL rst_cpu_gnt: %0h", CPU_GNT); end
    n_cmp++;
    if (DMA_GNT !== 1'b0) begin n_err++; $error("FAIL rst_dma_gnt: %0h", DMA_GNT); end
    n_cmp++;
    if (BACK_N !== 1'b1) begin n_err++; $error("FAIL rst_back_n: %0h", BACK_N); end
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL rst_owner: %0h", OWNER); end
    n_cmp++;
    if (DMA_ACK !== 1'b0) begin n_err++; $error("FAIL rst_dma_ack: %0h", DMA_ACK); end
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin
      n_err++;
      $error("FAIL rst_bus_idle: observed %0h expected 1", BUS_IDLE);
    end

    // First grant goes to DMAC over CPU.
    RST_N = 1'b1;
    tick_r();
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL first_dma_gnt: %0h", DMA_GNT); end
    n_cmp++;
    if (OWNER !== 2'd2) begin n_err++; $error("FAIL first_owner: %0h", OWNER); end
    n_cmp++;
    if (CPU_GNT !== 1'b0) begin n_err++; $error("FAIL first_cpu_gnt: %0h", CPU_GNT); end

    // Eight unlocked DMAC beats with CPU waiting.
    for (int i = 1; i <= 8; i++) begin
      tick_f();
      n_cmp++;
      if (DMA_ACK !== 1'b1) begin n_err++; $error("FAIL stream_ack %0d: %0h", i, DMA_ACK); end
      tick_r();
      if (i < 8) begin
        n_cmp++;
        if (DMA_GNT !== 1'b1) begin
          n_err++;
          $error("FAIL stream_dma_gnt %0d: %0h", i, DMA_GNT);
        end
      end
    end
`ifdef SH7604_ARB_FAIR_EN
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL fair_gap_owner: %0h", OWNER); end
    tick_f();
    tick_r();
    n_cmp++;
    if (CPU_GNT !== 1'b1) begin n_err++; $error("FAIL fair_cpu_gnt: %0h", CPU_GNT); end
`else
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL strict_dma_keeps: %0h", DMA_GNT); end
    tick_f();
    tick_r();
    n_cmp++;
    if (CPU_GNT !== 1'b0) begin n_err++; $error("FAIL strict_cpu_starved: %0h", CPU_GNT); end
`endif
    CPU_REQ = 1'b0; DMA_REQ = 1'b0;
    tick_f();
    tick_r();
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin n_err++; $error("FAIL drain_idle: %0h", BUS_IDLE); end

    // DMAC burst holds off both CPU and the external master.
    CPU_REQ = 1'b1; DMA_REQ = 1'b1; DMA_BURST = 1'b1;
    tick_r();
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL burst_gnt: %0h", DMA_GNT); end
    BREQ_N = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick_f();
      n_cmp++;
      if (DMA_ACK !== 1'b1) begin n_err++; $error("FAIL burst_ack %0d: %0h", i, DMA_ACK); end
      if (i == 3) begin
        DMA_BURST = 1'b0; DMA_REQ = 1'b0;
      end
      tick_r();
      if (i < 4) begin
        n_cmp++;
        if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL burst_hold %0d: %0h", i, DMA_GNT); end
        n_cmp++;
        if (BACK_N !== 1'b1) begin n_err++; $error("FAIL burst_back_n %0d: %0h", i, BACK_N); end
      end
    end
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL burst_gap_owner: %0h", OWNER); end
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin n_err++; $error("FAIL burst_gap_idle: %0h", BUS_IDLE); end
    n_cmp++;
    if (DMA_ACK !== 1'b0) begin n_err++; $error("FAIL burst_gap_ack: %0h", DMA_ACK); end
    tick_f();
    tick_r();
    n_cmp++;
    if (BUS_IDLE !== 1'b0) begin n_err++; $error("FAIL turn_in_idle: %0h", BUS_IDLE); end
    n_cmp++;
    if (BACK_N !== 1'b1) begin n_err++; $error("FAIL turn_in_back_n: %0h", BACK_N); end
    tick_f();
    tick_r();
    n_cmp++;
    if (BACK_N !== 1'b0) begin n_err++; $error("FAIL ext_back_n: %0h", BACK_N); end
    n_cmp++;
    if (OWNER !== 2'd3) begin n_err++; $error("FAIL ext_owner: %0h", OWNER); end

    // Internal requests wait during EXT; on release: TURN, IDLE, then DMAC.
    DMA_REQ = 1'b1;
    tick_f();
    tick_r();
    n_cmp++;
    if (DMA_GNT !== 1'b0) begin n_err++; $error("FAIL ext_hold_dma: %0h", DMA_GNT); end
    n_cmp++;
    if (CPU_GNT !== 1'b0) begin n_err++; $error("FAIL ext_hold_cpu: %0h", CPU_GNT); end
    BREQ_N = 1'b1;
    tick_f();
    tick_r();
    n_cmp++;
    if (BACK_N !== 1'b1) begin n_err++; $error("FAIL rel_back_n: %0h", BACK_N); end
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL rel_owner: %0h", OWNER); end
    n_cmp++;
    if (BUS_IDLE !== 1'b0) begin n_err++; $error("FAIL rel_turn: %0h", BUS_IDLE); end
    tick_f();
    tick_r();
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin n_err++; $error("FAIL rel_idle: %0h", BUS_IDLE); end
    tick_f();
    tick_r();
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL rel_dma_gnt: %0h", DMA_GNT); end

    // CPU locked sequence of two beats keeps the bus from a waiting DMAC.
    DMA_REQ = 1'b0; CPU_LOCK = 1'b1;
    tick_f();
    tick_r();
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL lock_gap: %0h", OWNER); end
    tick_f();
    tick_r();
    n_cmp++;
    if (CPU_GNT !== 1'b1) begin n_err++; $error("FAIL lock_cpu_gnt: %0h", CPU_GNT); end
    n_cmp++;
    if (OWNER !== 2'd1) begin n_err++; $error("FAIL lock_owner: %0h", OWNER); end
    DMA_REQ = 1'b1;
    tick_f();
    n_cmp++;
    if (DMA_ACK !== 1'b0) begin n_err++; $error("FAIL lock_no_ack: %0h", DMA_ACK); end
    tick_r();
    n_cmp++;
    if (CPU_GNT !== 1'b1) begin n_err++; $error("FAIL lock_hold1: %0h", CPU_GNT); end
    tick_f();
    tick_r();
    n_cmp++;
    if (CPU_GNT !== 1'b1) begin n_err++; $error("FAIL lock_hold2: %0h", CPU_GNT); end
    CPU_LOCK = 1'b0; CPU_REQ = 1'b0;
    tick_f();
    tick_r();
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL unlock_gap: %0h", OWNER); end
    tick_f();
    tick_r();
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL unlock_dma_gnt: %0h", DMA_GNT); end
    n_cmp++;
    if (OWNER !== 2'd2) begin n_err++; $error("FAIL unlock_owner: %0h", OWNER); end

    // Reset in the middle of a waited DMAC beat.
    BUS_WAIT = 1'b1;
    tick_f();
    n_cmp++;
    if (DMA_ACK !== 1'b0) begin
      n_err++;
      $error("FAIL wait_no_ack: observed %0h expected 0", DMA_ACK);
    end
    n_cmp++;
    if (DMA_GNT !== 1'b1) begin n_err++; $error("FAIL wait_dma_gnt: %0h", DMA_GNT); end
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (DMA_GNT !== 1'b0) begin n_err++; $error("FAIL midrst_dma_gnt: %0h", DMA_GNT); end
    n_cmp++;
    if (OWNER !== 2'd0) begin n_err++; $error("FAIL midrst_owner: %0h", OWNER); end
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin n_err++; $error("FAIL midrst_idle: %0h", BUS_IDLE); end
    DMA_REQ = 1'b0; BUS_WAIT = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (DMA_ACK !== 1'b0) begin n_err++; $error("FAIL midrst_ack: %0h", DMA_ACK); end
    RST_N = 1'b1;
    tick_r();
    n_cmp++;
    if (BUS_IDLE !== 1'b1) begin n_err++; $error("FAIL post_rst_idle: %0h", BUS_IDLE); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err != 0) $error("FAIL: %0d mismatches", n_err);
    $finish;
  end

endmodule
